// File: rtl/clk_reset_sequencer.sv
// Clock-wizard supervisor: pulses pll_reset, qualifies a stable lock, then releases domain resets in order.
// All outputs registered (1 cycle after the deciding edge); lock is seen 2 cycles late through a synchronizer.
module clk_reset_sequencer #(
    parameter int PLL_RST_CYC      = 32,
    parameter int LOCK_TIMEOUT_CYC = 1000000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int NUM_STAGES       = 3,
    parameter int STAGE_GAP_CYC    = 16,
    parameter int CNT_W            = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked_async,
    input  logic                  force_restart,
    output logic                  pll_reset,
    output logic [NUM_STAGES-1:0] dom_rst_n,
    output logic                  sys_ready,
    output logic                  lock_lost_pulse,
    output logic [CNT_W-1:0]      lock_loss_cnt,
    output logic [CNT_W-1:0]      timeout_cnt,
    output logic [2:0]            state_o
);
    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    localparam int REL_CYC = NUM_STAGES * STAGE_GAP_CYC;
    localparam int MAX_A   = (PLL_RST_CYC > LOCK_TIMEOUT_CYC) ? PLL_RST_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_B   = (LOCK_STABLE_CYC > REL_CYC) ? LOCK_STABLE_CYC : REL_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW      = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] PLL_LAST    = TW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] REL_LAST    = TW'(REL_CYC - 1);

    logic                  lock_meta_q, locked_s_q;
    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  to_hit, loss_hit;
    logic                  pll_reset_q, pll_reset_d;
    logic [NUM_STAGES-1:0] dom_rst_n_q, dom_rst_n_d;
    logic                  sys_ready_q, sys_ready_d;
    logic                  lost_q, lost_d;
    logic [CNT_W-1:0]      loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= S_PLL_RST;
            tmr_q       <= '0;
        end else begin
            lock_meta_q <= pll_locked_async;
            locked_s_q  <= lock_meta_q;
            state_q     <= state_d;
            tmr_q       <= tmr_d;
        end
    end

    // tmr_q is the cycle count since entering the current state; every transition zeroes it.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 1'b1;
        to_hit   = 1'b0;
        loss_hit = 1'b0;
        if (force_restart) begin
            state_d = S_PLL_RST;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                S_PLL_RST: begin
                    if (tmr_q == PLL_LAST) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_STABLE;
                        tmr_d   = '0;
                    end else if (tmr_q == TO_LAST) begin
                        state_d = S_PLL_RST;
                        tmr_d   = '0;
                        to_hit  = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s_q) begin
                        state_d = S_WAIT_LOCK;
                        tmr_d   = '0;
                    end else if (tmr_q == STABLE_LAST) begin
                        state_d = S_RELEASE;
                        tmr_d   = '0;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s_q) begin
                        state_d = S_PLL_RST;
                        tmr_d   = '0;
                    end else if (tmr_q == REL_LAST) begin
                        state_d = S_RUN;
                        tmr_d   = '0;
                    end
                end
                S_RUN: begin
                    tmr_d = '0;
                    if (!locked_s_q) begin
                        state_d  = S_PLL_RST;
                        loss_hit = 1'b1;
                    end
                end
                default: begin
                    state_d = S_PLL_RST;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        pll_reset_d = (state_d == S_PLL_RST);
        sys_ready_d = (state_d == S_RUN);
        lost_d      = loss_hit;
        dom_rst_n_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (state_d == S_RUN ||
                (state_d == S_RELEASE && int'(tmr_d) >= i * STAGE_GAP_CYC)) begin
                dom_rst_n_d[i] = 1'b1;
            end
        end
        loss_cnt_d = (loss_hit && loss_cnt_q != '1) ? loss_cnt_q + 1'b1 : loss_cnt_q;
        to_cnt_d   = (to_hit && to_cnt_q != '1) ? to_cnt_q + 1'b1 : to_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pll_reset_q <= 1'b1;
            dom_rst_n_q <= '0;
            sys_ready_q <= 1'b0;
            lost_q      <= 1'b0;
            loss_cnt_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            pll_reset_q <= pll_reset_d;
            dom_rst_n_q <= dom_rst_n_d;
            sys_ready_q <= sys_ready_d;
            lost_q      <= lost_d;
            loss_cnt_q  <= loss_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign pll_reset       = pll_reset_q;
    assign dom_rst_n       = dom_rst_n_q;
    assign sys_ready       = sys_ready_q;
    assign lock_lost_pulse = lost_q;
    assign lock_loss_cnt   = loss_cnt_q;
    assign timeout_cnt     = to_cnt_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: directed scenarios plus random lock/force traffic against a reference model.
module tb_clk_reset_sequencer;
    localparam int PLL_RST_CYC      = 5;
    localparam int LOCK_TIMEOUT_CYC = 50;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int NUM_STAGES       = 3;
    localparam int STAGE_GAP_CYC    = 4;
    localparam int CNT_W            = 4;
    localparam int CNT_MAX          = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pll_locked_async = 1'b0;
    logic        force_restart = 1'b0;
    logic        pll_reset;
    logic [2:0]  dom_rst_n;
    logic        sys_ready;
    logic        lock_lost_pulse;
    logic [3:0]  lock_loss_cnt;
    logic [3:0]  timeout_cnt;
    logic [2:0]  state_o;
    logic [16:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;

    clk_reset_sequencer #(
        .PLL_RST_CYC(PLL_RST_CYC), .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .LOCK_STABLE_CYC(LOCK_STABLE_CYC), .NUM_STAGES(NUM_STAGES),
        .STAGE_GAP_CYC(STAGE_GAP_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked_async(pll_locked_async),
        .force_restart(force_restart), .pll_reset(pll_reset), .dom_rst_n(dom_rst_n),
        .sys_ready(sys_ready), .lock_lost_pulse(lock_lost_pulse),
        .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pll_reset, dom_rst_n, sys_ready, lock_lost_pulse, lock_loss_cnt, timeout_cnt, state_o};

    // Reference model: phase number, cycles spent in it, and a 2-deep delay line for lock.
    int m_st = 0, m_age = 0, m_loss = 0, m_to = 0;
    bit m_pulse = 1'b0;
    bit m_lq[$];

    task automatic model_edge(input bit rn, input bit lk, input bit fr);
        bit ls;
        if (!rn) begin
            m_st = 0; m_age = 0; m_loss = 0; m_to = 0; m_pulse = 1'b0;
            m_lq.delete();
            m_lq.push_back(1'b0);
            m_lq.push_back(1'b0);
            return;
        end
        ls = m_lq.pop_front();
        m_lq.push_back(lk);
        m_pulse = 1'b0;
        if (fr) begin
            m_st = 0; m_age = 0;
        end else begin
            case (m_st)
                0: if (m_age == PLL_RST_CYC - 1) begin m_st = 1; m_age = 0; end else m_age++;
                1: if (ls) begin m_st = 2; m_age = 0; end
                   else if (m_age == LOCK_TIMEOUT_CYC - 1) begin
                       m_st = 0; m_age = 0;
                       if (m_to < CNT_MAX) m_to++;
                   end else m_age++;
                2: if (!ls) begin m_st = 1; m_age = 0; end
                   else if (m_age == LOCK_STABLE_CYC - 1) begin m_st = 3; m_age = 0; end
                   else m_age++;
                3: if (!ls) begin m_st = 0; m_age = 0; end
                   else if (m_age == NUM_STAGES * STAGE_GAP_CYC - 1) begin m_st = 4; m_age = 0; end
                   else m_age++;
                default: if (!ls) begin
                       m_st = 0; m_age = 0; m_pulse = 1'b1;
                       if (m_loss < CNT_MAX) m_loss++;
                   end
            endcase
        end
    endtask

    function automatic logic [16:0] m_vec();
        logic [2:0] dom;
        int rel;
        dom = 3'b000;
        if (m_st == 4) dom = 3'b111;
        else if (m_st == 3) begin
            rel = m_age / STAGE_GAP_CYC + 1;
            dom = 3'((1 << rel) - 1);
        end
        return {m_st == 0, dom, m_st == 4, m_pulse, 4'(m_loss), 4'(m_to), 3'(m_st)};
    endfunction

    task automatic step(input bit rn, input bit lk, input bit fr);
        @(negedge clk);
        rst_n = rn;
        pll_locked_async = lk;
        force_restart = fr;
        @(posedge clk);
        model_edge(rn, lk, fr);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL reset_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
        vectors++;
        if ({pll_reset, dom_rst_n, sys_ready, lock_lost_pulse, lock_loss_cnt, timeout_cnt, state_o} !== 17'b1_000_0_0_0000_0000_000) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, 17'h10000);
        end
    endtask

    task automatic test_power_up();
        int t0 = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL powerup_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
            if (i <= 4) begin
                vectors++;
                if (pll_reset !== (i < 4)) begin
                    miscompares++;
                    $display("FAIL powerup_pll_reset step %0d: got %b expected %b", i, pll_reset, i < 4);
                end
            end
            if (t0 < 0 && dom_rst_n === 3'b001) t0 = i;
            if (t0 >= 0 && i == t0 + 4) begin
                vectors++;
                if (dom_rst_n !== 3'b011) begin
                    miscompares++;
                    $display("FAIL powerup_stage1: got %b expected 011", dom_rst_n);
                end
            end
            if (t0 >= 0 && i == t0 + 8) begin
                vectors++;
                if (dom_rst_n !== 3'b111 || sys_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL powerup_stage2: got %b/%b expected 111/0", dom_rst_n, sys_ready);
                end
            end
            if (t0 >= 0 && i == t0 + 12) begin
                vectors++;
                if (sys_ready !== 1'b1 || state_o !== 3'd4) begin
                    miscompares++;
                    $display("FAIL powerup_run: got %b/%0d expected 1/4", sys_ready, state_o);
                end
            end
        end
        vectors++;
        if (t0 != 13) begin
            miscompares++;
            $display("FAIL powerup_first_release: got step %0d expected 13", t0);
        end
    endtask

    task automatic test_lock_loss();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL loss_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
            if (i < 2) begin
                vectors++;
                if (state_o !== 3'd4 || sys_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL loss_latency step %0d: got %0d/%b expected 4/1", i, state_o, sys_ready);
                end
            end
            if (i == 2) begin
                vectors++;
                if ({dom_rst_n, sys_ready, lock_lost_pulse, lock_loss_cnt, state_o} !== {3'b000, 1'b0, 1'b1, 4'd1, 3'd0}) begin
                    miscompares++;
                    $display("FAIL loss_event: got %b %b %b %0d %0d expected 000 0 1 1 0",
                             dom_rst_n, sys_ready, lock_lost_pulse, lock_loss_cnt, state_o);
                end
            end
            if (i == 3) begin
                vectors++;
                if (lock_lost_pulse !== 1'b0) begin
                    miscompares++;
                    $display("FAIL loss_pulse_width: got %b expected 0", lock_lost_pulse);
                end
            end
        end
        for (int i = 0; i < 80 && state_o !== 3'd4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL loss_recover_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
        vectors++;
        if (state_o !== 3'd4) begin
            miscompares++;
            $display("FAIL loss_recover: got state %0d expected 4", state_o);
        end
    endtask

    task automatic test_stable_glitch();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40 && state_o !== 3'd2; i++) begin
            step(1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL glitch_wait_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
        vectors++;
        if (state_o !== 3'd2) begin
            miscompares++;
            $display("FAIL glitch_reach_stable: got state %0d expected 2", state_o);
        end
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, k != 4, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL glitch_model step %0d: got %h expected %h", k, dut_vec, m_vec());
            end
            if (k == 6) begin
                vectors++;
                if (state_o !== 3'd1) begin
                    miscompares++;
                    $display("FAIL glitch_back_to_wait: got state %0d expected 1", state_o);
                end
            end
            if (k < 15) begin
                vectors++;
                if (dom_rst_n !== 3'b000) begin
                    miscompares++;
                    $display("FAIL glitch_early_release step %0d: got %b expected 000", k, dom_rst_n);
                end
            end else begin
                vectors++;
                if (dom_rst_n !== 3'b001 || state_o !== 3'd3) begin
                    miscompares++;
                    $display("FAIL glitch_release: got %b/%0d expected 001/3", dom_rst_n, state_o);
                end
            end
        end
    endtask

    task automatic test_force_in_release();
        for (int i = 0; i < 10 && dom_rst_n !== 3'b011; i++) begin
            step(1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL force_wait_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if (dom_rst_n !== 3'b011) begin
            miscompares++;
            $display("FAIL force_mid_release: got %b expected 011", dom_rst_n);
        end
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if ({state_o, dom_rst_n, sys_ready, lock_lost_pulse, lock_loss_cnt, timeout_cnt} !== {3'd0, 3'b000, 1'b0, 1'b0, 4'd1, 4'd0}) begin
            miscompares++;
            $display("FAIL force_restart: got %h expected state 0, dom 000, counters 1/0", dut_vec);
        end
        vectors++;
        if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL force_model: got %h expected %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_timeout();
        logic [2:0] prev_st;
        logic       prev_pr;
        int retries = 0, last_t = -1, hi_len = 0;
        prev_st = state_o;
        prev_pr = pll_reset;
        for (int i = 0; i < 1150; i++) begin
            step(1'b1, 1'b0, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL timeout_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
            if (pll_reset === 1'b1) hi_len++;
            if (prev_pr === 1'b1 && pll_reset === 1'b0) begin
                if (retries >= 1) begin
                    vectors++;
                    if (hi_len != PLL_RST_CYC) begin
                        miscompares++;
                        $display("FAIL timeout_pulse_len: got %0d expected %0d", hi_len, PLL_RST_CYC);
                    end
                end
                hi_len = 0;
            end
            if (prev_st === 3'd1 && state_o === 3'd0) begin
                retries++;
                if (last_t >= 0) begin
                    vectors++;
                    if (i - last_t != PLL_RST_CYC + LOCK_TIMEOUT_CYC) begin
                        miscompares++;
                        $display("FAIL timeout_period: got %0d expected %0d", i - last_t, PLL_RST_CYC + LOCK_TIMEOUT_CYC);
                    end
                end
                last_t = i;
                vectors++;
                if (timeout_cnt !== 4'((retries > CNT_MAX) ? CNT_MAX : retries)) begin
                    miscompares++;
                    $display("FAIL timeout_count retry %0d: got %0d", retries, timeout_cnt);
                end
            end
            prev_st = state_o;
            prev_pr = pll_reset;
        end
        vectors++;
        if (retries < 16 || timeout_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL timeout_saturate: got %0d after %0d retries expected 15", timeout_cnt, retries);
        end
    endtask

    task automatic test_reset_in_run();
        for (int i = 0; i < 100 && state_o !== 3'd4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL rstrun_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
        vectors++;
        if (state_o !== 3'd4) begin
            miscompares++;
            $display("FAIL rstrun_reach_run: got state %0d expected 4", state_o);
        end
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (dut_vec !== 17'b1_000_0_0_0000_0000_000) begin
            miscompares++;
            $display("FAIL rstrun_values: got %h expected %h", dut_vec, 17'h10000);
        end
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if (dut_vec !== m_vec()) begin
            miscompares++;
            $display("FAIL rstrun_after: got %h expected %h", dut_vec, m_vec());
        end
    endtask

    task automatic test_random();
        bit lk = 1'b1;
        bit fr;
        for (int i = 0; i < 2000; i++) begin
            if (lk) lk = ($urandom_range(0, 59) != 0);
            else    lk = ($urandom_range(0, 5) == 0);
            fr = ($urandom_range(0, 199) == 0);
            step(1'b1, lk, fr);
            vectors++;
            if (dut_vec !== m_vec()) begin
                miscompares++;
                $display("FAIL random_model step %0d: got %h expected %h", i, dut_vec, m_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_stable_glitch();
        test_force_in_release();
        test_timeout();
        test_reset_in_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
